mmio_reduce_fifo: RTL and testbench

//   Register-mapped N-channel reduction engine. Software pushes DW-bit operands into NCH input FIFOs.

---
 rtl/mmio_reduce_fifo_pkg.sv | 25 ++
 rtl/mmio_reduce_fifo_if.sv | 27 ++
 rtl/mmio_reduce_fifo_sync_fifo.sv | 74 +++++++
 rtl/mmio_reduce_fifo.sv | 133 +++++++++++++
 tb/tb_mmio_reduce_fifo.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/mmio_reduce_fifo_pkg.sv
// Shared constants for the register-mapped reduction engine: register map,
// operator encodings and the sticky error record.
package mmio_reduce_pkg;

  localparam int unsigned ADDR_STATUS    = 32'h0;
  localparam int unsigned ADDR_OUT_DATA  = 32'h1;
  localparam int unsigned ADDR_MODE      = 32'h2;
  localparam int unsigned ADDR_OUT_COUNT = 32'h3;
  localparam int unsigned ADDR_CTRL      = 32'h4;
  localparam int unsigned ADDR_ERR       = 32'h5;
  localparam int unsigned ADDR_PUSH_BASE = 32'h8;

  typedef enum logic [1:0] {
    OP_OR  = 2'd0,
    OP_AND = 2'd1,
    OP_XOR = 2'd2,
    OP_ADD = 2'd3
  } op_e;

  typedef struct packed {
    logic underflow;
    logic overflow;
  } err_t;

endpackage

// File: rtl/mmio_reduce_fifo_if.sv
// Peripheral write/read bus shared by the reduction engine and its host.
interface mmio_reduce_fifo_if #(
  parameter int AW = 4,
  parameter int DW = 8
) ();

  logic [AW-1:0] write_address;
  logic [DW-1:0] write_data;
  logic          write_en;
  logic          write_rdy;
  logic [AW-1:0] read_address;
  logic          read_en;
  logic [DW-1:0] read_data;
  logic          read_valid;
  logic          read_rdy;

  modport master (
    output write_address, write_data, write_en, read_address, read_en,
    input  write_rdy, read_data, read_valid, read_rdy
  );

  modport slave (
    input  write_address, write_data, write_en, read_address, read_en,
    output write_rdy, read_data, read_valid, read_rdy
  );

endinterface

// File: rtl/mmio_reduce_fifo_sync_fifo.sv
// Single-clock FIFO with count-based full/empty and a synchronous clear that
// beats any same-edge push or pop.
module sync_fifo #(
  parameter  int DW    = 8,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // Full is judged on the pre-edge count, so a push at DEPTH is refused even
  // when a pop happens on the same edge.
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full && !clr;
  assign do_pop  = pop && !empty && !clr;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only observable once
  // the count says it was written.
  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mmio_reduce_fifo.sv
// N-channel reduction engine: software fills NCH input FIFOs, matched entries
// are combined with the MODE operator and queued for software to read back.
module mmio_reduce_fifo
  import mmio_reduce_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int DW        = 8,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4,
  parameter int AW        = 4
) (
  input  logic               CLK,
  input  logic               RST_N,
  mmio_reduce_fifo_if.slave  bus
);

  localparam int ICW = $clog2(IN_DEPTH) + 1;
  localparam int OCW = $clog2(OUT_DEPTH) + 1;

  logic [DW-1:0]  in_dout [NCH];
  logic [ICW-1:0] in_count [NCH];
  logic [NCH-1:0] in_full, in_empty, in_push, in_at_depth;
  logic [DW-1:0]  out_dout;
  logic [OCW-1:0] out_count;
  logic           out_full, out_empty, out_pop;

  logic           flush, fire, wr_mode, rd_out, rd_err, overflow, underflow;
  logic [DW-1:0]  result;

  op_e            mode_q, mode_d;
  err_t           err_q, err_d;
  logic [DW-1:0]  read_data_q, read_data_d;
  logic           read_valid_q, read_valid_d;

  assign bus.write_rdy  = 1'b1;
  assign bus.read_rdy   = 1'b1;
  assign bus.read_data  = read_data_q;
  assign bus.read_valid = read_valid_q;

  assign flush     = bus.write_en && (bus.write_address == AW'(ADDR_CTRL)) && bus.write_data[0];
  assign wr_mode   = bus.write_en && (bus.write_address == AW'(ADDR_MODE));
  assign rd_out    = bus.read_en && (bus.read_address == AW'(ADDR_OUT_DATA));
  assign rd_err    = bus.read_en && (bus.read_address == AW'(ADDR_ERR));
  assign out_pop   = rd_out && !out_empty;
  assign underflow = rd_out && out_empty;
  assign overflow  = |(in_push & in_at_depth);
  assign fire      = !(|in_empty) && !out_full;

  for (genvar i = 0; i < NCH; i++) begin : g_in
    assign in_push[i]     = bus.write_en && (bus.write_address == AW'(ADDR_PUSH_BASE + i));
    assign in_at_depth[i] = (in_count[i] == ICW'(IN_DEPTH));

    sync_fifo #(.DW(DW), .DEPTH(IN_DEPTH)) u_in_fifo (
      .CLK   (CLK),
      .RST_N (RST_N),
      .clr   (flush),
      .push  (in_push[i]),
      .pop   (fire),
      .din   (bus.write_data),
      .dout  (in_dout[i]),
      .full  (in_full[i]),
      .empty (in_empty[i]),
      .count (in_count[i])
    );
  end

  sync_fifo #(.DW(DW), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .CLK   (CLK),
    .RST_N (RST_N),
    .clr   (flush),
    .push  (fire),
    .pop   (out_pop),
    .din   (result),
    .dout  (out_dout),
    .full  (out_full),
    .empty (out_empty),
    .count (out_count)
  );

  always_comb begin
    result = in_dout[0];
    for (int i = 1; i < NCH; i++) begin
      case (mode_q)
        OP_OR:  result = result | in_dout[i];
        OP_AND: result = result & in_dout[i];
        OP_XOR: result = result ^ in_dout[i];
        OP_ADD: result = result + in_dout[i];
      endcase
    end
  end

  always_comb begin
    mode_d = mode_q;
    if (wr_mode) mode_d = op_e'(bus.write_data[1:0]);

    // A read clears ERR, but an error raised on the same edge survives it.
    err_d = rd_err ? '0 : err_q;
    err_d.overflow  = err_d.overflow  | overflow;
    err_d.underflow = err_d.underflow | underflow;

    read_valid_d = bus.read_en;
    read_data_d  = read_data_q;
    if (bus.read_en) begin
      read_data_d = '0;
      case (bus.read_address)
        AW'(ADDR_STATUS): begin
          read_data_d[NCH-1:0] = ~in_full;
          read_data_d[NCH]     = ~out_empty;
        end
        AW'(ADDR_OUT_DATA):  read_data_d = out_empty ? '0 : out_dout;
        AW'(ADDR_MODE):      read_data_d = DW'(mode_q);
        AW'(ADDR_OUT_COUNT): read_data_d = DW'(out_count);
        AW'(ADDR_ERR):       read_data_d = DW'(err_q);
        default:             read_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mode_q       <= OP_OR;
      err_q        <= '0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      err_q        <= err_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
    end
  end

endmodule

// File: tb/tb_mmio_reduce_fifo.sv
// Directed bench for mmio_reduce_fifo (NCH=2, DW=8): expected read data is
// queued at issue time and compared by a monitor whenever read_valid is seen.
module tb_mmio_reduce_fifo;

  localparam int AW = 4;
  localparam int DW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] exp_q [$];
  string         name_q [$];
  logic [DW-1:0] mon_exp;
  string         mon_name;

  always #5 clk = ~clk;

  mmio_reduce_fifo_if #(.AW(AW), .DW(DW)) bus ();

  mmio_reduce_fifo #(
    .NCH(2), .DW(DW), .IN_DEPTH(4), .OUT_DEPTH(4), .AW(AW)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  // Monitor: every read_valid pulse consumes one queued expectation.
  always @(negedge clk) begin
    if (rst_n && bus.read_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_read_valid: read_valid=1 with nothing outstanding, read_data=0x%02h",
                 bus.read_data);
      end else begin
        mon_name = name_q.pop_front();
        mon_exp  = exp_q.pop_front();
        check(mon_name, bus.read_data, mon_exp);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.write_address = a;
    bus.write_data    = d;
    bus.write_en      = 1'b1;
    @(posedge clk);
    #1;
    bus.write_en = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
    bus.read_address = a;
    bus.read_en      = 1'b1;
    @(posedge clk);
    #1;
    bus.read_en = 1'b0;
  endtask

  initial begin
    bus.write_address = '0;
    bus.write_data    = '0;
    bus.write_en      = 1'b0;
    bus.read_address  = '0;
    bus.read_en       = 1'b0;

    #23 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_read_valid", DW'(bus.read_valid), 8'h00);
    check("reset_read_data", bus.read_data, 8'h00);
    check("write_rdy", DW'(bus.write_rdy), 8'h01);

    // Traffic with a result queued, an overflow and a MODE change, then an
    // asynchronous reset pulse in the middle of a cycle.
    wr(4'h8, 8'h11);
    wr(4'h9, 8'h22);
    repeat (5) wr(4'h8, 8'h33);
    wr(4'h2, 8'h02);
    #3 rst_n = 1'b0;
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;
    rd(4'h0, 8'h03, "status_after_reset");
    rd(4'h5, 8'h00, "err_after_reset");
    rd(4'h2, 8'h00, "mode_after_reset");
    rd(4'h3, 8'h00, "count_after_reset");

    // OR
    wr(4'h8, 8'h0F);
    wr(4'h9, 8'hF0);
    idle(1);
    rd(4'h1, 8'hFF, "or_result");
    rd(4'h3, 8'h00, "count_after_pop");

    // ADD wraps modulo 256
    wr(4'h2, 8'h03);
    wr(4'h8, 8'hFF);
    wr(4'h9, 8'h02);
    idle(1);
    rd(4'h1, 8'h01, "add_wrap");

    // XOR
    wr(4'h2, 8'h02);
    wr(4'h8, 8'hAA);
    wr(4'h9, 8'hFF);
    idle(1);
    rd(4'h1, 8'h55, "xor_result");
    rd(4'h2, 8'h02, "mode_readback");

    // Fill everything with ADD pairs: ch0 = j*16, ch1 = j+1 -> result j*17+1
    wr(4'h2, 8'h03);
    for (int j = 0; j < 8; j++) begin
      wr(4'h8, DW'(j * 16));
      wr(4'h9, DW'(j + 1));
    end
    idle(2);
    rd(4'h3, 8'h04, "fill_out_count");
    rd(4'h0, 8'h04, "fill_status");
    wr(4'h8, 8'h99);
    rd(4'h5, 8'h01, "err_overflow");
    rd(4'h5, 8'h00, "err_cleared");
    for (int j = 0; j < 8; j++) begin
      rd(4'h1, DW'(j * 16 + j + 1), $sformatf("fill_pop_%0d", j));
    end
    rd(4'h3, 8'h00, "drained_count");

    // Underflow
    rd(4'h1, 8'h00, "empty_pop");
    rd(4'h5, 8'h02, "err_underflow");

    // Flush discards the lone ch0 entry, so a later lone ch1 push pairs with nothing.
    wr(4'h8, 8'h33);
    wr(4'h4, 8'h01);
    rd(4'h0, 8'h03, "status_after_flush");
    wr(4'h9, 8'h44);
    idle(2);
    rd(4'h3, 8'h00, "no_result_after_flush");
    rd(4'h0, 8'h03, "status_lone_ch1");
    rd(4'h7, 8'h00, "unmapped_read");

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d reads still outstanding, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
